// File: rtl/instr_fetch_unit_if.sv
// Program-memory fetch bus between the instruction fetch unit (master)
// and program memory (slave). Single outstanding request, one-cycle ack.
interface instr_fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
);
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches words from program memory
// over a req/ack bus and presents Opcode/Imm to the controller. Opcode and
// Imm come from an output register stage that trails IR by one cycle, while
// PC jumps use the Imm field of IR itself.
module instr_fetch_unit #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic                 CLK,
    input  logic                 CLB,
    input  logic                 LoadIR,
    input  logic                 IncPC,
    input  logic                 SelPC,
    input  logic                 LoadPC,
    input  logic [PC_W-1:0]      RegData,
    instr_fetch_unit_if.master   mem,
    output logic [3:0]           Opcode,
    output logic [INSTR_W-5:0]   Imm,
    output logic [PC_W-1:0]      PC,
    output logic                 fetch_busy,
    output logic                 fetch_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    // Last WAIT cycle index: the fetch is abandoned when no ack has arrived by it
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]         state_r,     stateNext_s;
    logic [7:0]         cnt_r,       cntNext_s;
    logic               memReq_r,    memReqNext_s;
    logic [PC_W-1:0]    fetchAddr_r, fetchAddrNext_s;
    logic [INSTR_W-1:0] ir_r,        irNext_s;
    logic               fetchErr_r,  fetchErrNext_s;
    logic [PC_W-1:0]    pc_r,        pcNext_s;
    logic [3:0]         opcode_r;
    logic [INSTR_W-5:0] imm_r;
    logic [PC_W-1:0]    immExt_s;

    // Fetch FSM: launch on LoadIR in IDLE, complete on ack or abort on timeout
    always_comb begin
        stateNext_s     = state_r;
        cntNext_s       = cnt_r;
        memReqNext_s    = memReq_r;
        fetchAddrNext_s = fetchAddr_r;
        irNext_s        = ir_r;
        fetchErrNext_s  = fetchErr_r;
        case (state_r)
            IDLE: begin
                if (LoadIR) begin
                    stateNext_s     = WAIT;
                    memReqNext_s    = 1'b1;
                    fetchAddrNext_s = pc_r;
                    cntNext_s       = 8'd0;
                end else begin
                    memReqNext_s    = 1'b0;
                end
            end
            WAIT: begin
                if (mem.mem_ack) begin
                    // An ack on the final wait cycle still counts as success
                    irNext_s     = mem.mem_rdata;
                    memReqNext_s = 1'b0;
                    stateNext_s  = IDLE;
                    cntNext_s    = 8'd0;
                end else if (cnt_r == CNT_LAST) begin
                    irNext_s       = {INSTR_W{1'b0}};
                    fetchErrNext_s = 1'b1;
                    memReqNext_s   = 1'b0;
                    stateNext_s    = IDLE;
                    cntNext_s      = 8'd0;
                end else begin
                    cntNext_s = cnt_r + 8'd1;
                end
            end
            default: begin
                stateNext_s  = IDLE;
                memReqNext_s = 1'b0;
                cntNext_s    = 8'd0;
            end
        endcase
    end

    // PC source selection: LoadPC beats IncPC; jumps use the committed IR
    always_comb begin
        immExt_s = PC_W'(ir_r[INSTR_W-5:0]);
        if (LoadPC) begin
            if (SelPC) begin
                pcNext_s = immExt_s;
            end else begin
                pcNext_s = RegData;
            end
        end else if (IncPC) begin
            pcNext_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end else begin
            pcNext_s = pc_r;
        end
    end

    // State, fetch bookkeeping, PC and output registers
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            memReq_r    <= 1'b0;
            fetchAddr_r <= {PC_W{1'b0}};
            ir_r        <= {INSTR_W{1'b0}};
            fetchErr_r  <= 1'b0;
            pc_r        <= PC_W'(RESET_PC);
            opcode_r    <= 4'd0;
            imm_r       <= {(INSTR_W-4){1'b0}};
        end else begin
            state_r     <= stateNext_s;
            cnt_r       <= cntNext_s;
            memReq_r    <= memReqNext_s;
            fetchAddr_r <= fetchAddrNext_s;
            ir_r        <= irNext_s;
            fetchErr_r  <= fetchErrNext_s;
            pc_r        <= pcNext_s;
            opcode_r    <= ir_r[INSTR_W-1 -: 4];
            imm_r       <= ir_r[INSTR_W-5:0];
        end
    end

    assign mem.mem_req  = memReq_r;
    assign mem.mem_addr = fetchAddr_r;
    assign fetch_busy   = memReq_r;
    assign fetch_err    = fetchErr_r;
    assign Opcode       = opcode_r;
    assign Imm          = imm_r;
    assign PC           = pc_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a PC-update vector table plus
// directed fetch, wait, timeout and asynchronous-reset sequences.
module tb_instr_fetch_unit;

    logic       CLK;
    logic       CLB;
    logic       LoadIR;
    logic       IncPC;
    logic       SelPC;
    logic       LoadPC;
    logic [7:0] RegData;
    logic [3:0] Opcode;
    logic [3:0] Imm;
    logic [7:0] PC;
    logic       fetch_busy;
    logic       fetch_err;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit_if #(.PC_W(8), .INSTR_W(8)) bus ();

    instr_fetch_unit #(
        .PC_W(8), .INSTR_W(8), .RESET_PC(0), .TIMEOUT(15)
    ) dut (
        .CLK(CLK), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
        .LoadPC(LoadPC), .RegData(RegData), .mem(bus.master), .Opcode(Opcode),
        .Imm(Imm), .PC(PC), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Program memory model: acks during the ackDelay-th cycle of a request
    logic [7:0] memArr [256];
    int         ackDelay = 1;
    bit         ackEn = 1'b1;
    int         reqCycles = 0;
    int         reqRises = 0;
    logic       prevReq = 1'b0;
    logic       modelAck = 1'b0;
    logic [7:0] modelData = 8'h00;
    logic       manualAck = 1'b0;
    logic [7:0] manualData = 8'h00;

    assign bus.mem_ack   = modelAck | manualAck;
    assign bus.mem_rdata = manualAck ? manualData : modelData;

    always @(posedge CLK) begin
        #1;
        if (bus.mem_req) begin
            reqCycles = reqCycles + 1;
            if (!prevReq) reqRises = reqRises + 1;
            if (ackEn && reqCycles == ackDelay) begin
                modelAck  = 1'b1;
                modelData = memArr[bus.mem_addr];
            end else begin
                modelAck = 1'b0;
            end
        end else begin
            reqCycles = 0;
            modelAck  = 1'b0;
        end
        prevReq = bus.mem_req;
    end

    typedef struct {
        logic       loadPC;
        logic       incPC;
        logic       selPC;
        logic [7:0] regData;
        logic [7:0] expPC;
    } pcVec_t;

    pcVec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic setPC(input logic [7:0] v);
        LoadPC = 1'b1; SelPC = 1'b0; RegData = v;
        tick();
        LoadPC = 1'b0;
        chk("setPC", {24'd0, PC}, {24'd0, v});
    endtask

    // Full fetch with an immediate ack: LoadIR pulse, then wait for Opcode
    task automatic fetchQuick(input logic [7:0] word, input string name);
        ackEn = 1'b1; ackDelay = 1;
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        tick();
        tick();
        chk({name, "_op"},  {28'd0, Opcode}, {28'd0, word[7:4]});
        chk({name, "_imm"}, {28'd0, Imm},    {28'd0, word[3:0]});
    endtask

    initial begin
        int rises0;
        for (int i = 0; i < 256; i++) memArr[i] = 8'h00;
        CLB = 1'b0; LoadIR = 1'b0; IncPC = 1'b0; SelPC = 1'b0; LoadPC = 1'b0; RegData = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_pc",   {24'd0, PC}, 32'h0);
        chk("rst_req",  {31'd0, bus.mem_req}, 32'h0);
        chk("rst_addr", {24'd0, bus.mem_addr}, 32'h0);
        chk("rst_busy", {31'd0, fetch_busy}, 32'h0);
        chk("rst_err",  {31'd0, fetch_err}, 32'h0);
        chk("rst_op",   {28'd0, Opcode}, 32'h0);
        CLB = 1'b1;
        tick();

        // 1: basic fetch with immediate ack, one-cycle request, 3-cycle latency
        memArr[8'h00] = 8'h1A;
        ackEn = 1'b1; ackDelay = 1;
        rises0 = reqRises;
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        chk("t1_req",  {31'd0, bus.mem_req}, 32'h1);
        chk("t1_addr", {24'd0, bus.mem_addr}, 32'h00);
        chk("t1_busy", {31'd0, fetch_busy}, 32'h1);
        tick();
        chk("t1_req_drop", {31'd0, bus.mem_req}, 32'h0);
        chk("t1_busy_drop", {31'd0, fetch_busy}, 32'h0);
        chk("t1_op_early", {28'd0, Opcode}, 32'h0);
        tick();
        chk("t1_op",  {28'd0, Opcode}, 32'h1);
        chk("t1_imm", {28'd0, Imm}, 32'hA);
        chk("t1_rises", reqRises - rises0, 32'd1);

        // 2/3: load IR=0x7C, then table of PC updates
        setPC(8'h30);
        memArr[8'h30] = 8'h7C;
        fetchQuick(8'h7C, "t2_fetch");
        vecs[0] = '{1'b1, 1'b1, 1'b1, 8'h99, 8'h0C};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h42, 8'h42};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h43};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h11, 8'h43};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h55, 8'h0C};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h0D};
        for (int i = 0; i < 8; i++) begin
            LoadPC = vecs[i].loadPC; IncPC = vecs[i].incPC;
            SelPC = vecs[i].selPC; RegData = vecs[i].regData;
            tick();
            chk($sformatf("pcvec%0d", i), {24'd0, PC}, {24'd0, vecs[i].expPC});
        end
        LoadPC = 1'b0; IncPC = 1'b0; SelPC = 1'b0;
        chk("t3_no_err", {31'd0, fetch_err}, 32'h0);

        // 4: slow ack after 5 cycles, PC moves but fetch address holds
        setPC(8'h10);
        memArr[8'h10] = 8'h3B;
        ackEn = 1'b1; ackDelay = 5;
        rises0 = reqRises;
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("t4_req%0d", i), {31'd0, bus.mem_req}, 32'h1);
            chk($sformatf("t4_addr%0d", i), {24'd0, bus.mem_addr}, 32'h10);
            IncPC  = (i == 1 || i == 3);
            LoadIR = (i == 2);
            tick();
        end
        IncPC = 1'b0; LoadIR = 1'b0;
        chk("t4_req_drop", {31'd0, bus.mem_req}, 32'h0);
        tick();
        tick();
        chk("t4_op",  {28'd0, Opcode}, 32'h3);
        chk("t4_imm", {28'd0, Imm}, 32'hB);
        chk("t4_pc",  {24'd0, PC}, 32'h12);
        chk("t4_rises", reqRises - rises0, 32'd1);

        // 5: timeout after 15 wait cycles, sticky error
        ackEn = 1'b0;
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            chk($sformatf("t5_req%0d", i), {31'd0, bus.mem_req}, 32'h1);
            tick();
        end
        chk("t5_req_drop", {31'd0, bus.mem_req}, 32'h0);
        chk("t5_err", {31'd0, fetch_err}, 32'h1);
        tick();
        chk("t5_op_nop",  {28'd0, Opcode}, 32'h0);
        chk("t5_imm_nop", {28'd0, Imm}, 32'h0);
        memArr[8'h12] = 8'h5E;
        fetchQuick(8'h5E, "t5_refetch");
        chk("t5_err_sticky", {31'd0, fetch_err}, 32'h1);

        // 5b: ack on the 15th wait cycle wins over timeout
        CLB = 1'b0;
        tick();
        chk("t5b_err_clr", {31'd0, fetch_err}, 32'h0);
        CLB = 1'b1;
        tick();
        memArr[8'h00] = 8'h96;
        ackEn = 1'b1; ackDelay = 15;
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            chk($sformatf("t5b_req%0d", i), {31'd0, bus.mem_req}, 32'h1);
            tick();
        end
        chk("t5b_req_drop", {31'd0, bus.mem_req}, 32'h0);
        chk("t5b_err", {31'd0, fetch_err}, 32'h0);
        tick();
        chk("t5b_op",  {28'd0, Opcode}, 32'h9);
        chk("t5b_imm", {28'd0, Imm}, 32'h6);

        // 6: asynchronous reset mid-wait, late ack ignored
        setPC(8'h20);
        ackEn = 1'b0;
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        chk("t6_req", {31'd0, bus.mem_req}, 32'h1);
        tick();
        #2;
        CLB = 1'b0;
        #1;
        chk("t6_req_async", {31'd0, bus.mem_req}, 32'h0);
        chk("t6_pc_async",  {24'd0, PC}, 32'h00);
        chk("t6_busy_async", {31'd0, fetch_busy}, 32'h0);
        tick();
        CLB = 1'b1;
        tick();
        manualData = 8'hFF; manualAck = 1'b1;
        tick();
        manualAck = 1'b0;
        tick();
        tick();
        chk("t6_op_late",  {28'd0, Opcode}, 32'h0);
        chk("t6_imm_late", {28'd0, Imm}, 32'h0);
        chk("t6_req_late", {31'd0, bus.mem_req}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the ControllerFSM in the single-cycle-per-state CPU.
- Owns the program counter (PC) and the instruction register (IR).
- Fetches instruction words from program memory over a req/ack handshake and presents Opcode/Imm to the controller.
- Executes the controller's LoadIR, IncPC, SelPC and LoadPC commands.

Parameters:
- PC_W, 8, program counter / memory address width.
- INSTR_W, 8, instruction width; Opcode = IR[INSTR_W-1:INSTR_W-4], Imm = IR[INSTR_W-5:0].
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, max cycles mem_req may wait for mem_ack before abort; range 1..255.

Ports:
- CLK  in  1  system clock, rising edge.
- CLB  in  1  asynchronous active-low reset (clear bar).
- LoadIR  in  1  controller: start a fetch at current PC.
- IncPC  in  1  controller: PC <= PC+1.
- SelPC  in  1  controller: PC source select; 0 = RegData, 1 = zero-extended Imm.
- LoadPC  in  1  controller: PC <= selected source.
- RegData  in  PC_W  register-file value for register jumps.
- mem_req  out  1  fetch request to program memory.
- mem_addr  out  PC_W  fetch address, stable while mem_req high.
- mem_rdata  in  INSTR_W  instruction word, valid when mem_ack high.
- mem_ack  in  1  memory completes the fetch (one-cycle pulse).
- Opcode  out  4  IR upper nibble, to controller.
- Imm  out  INSTR_W-4  IR low field, to controller/datapath.
- PC  out  PC_W  current program counter.
- fetch_busy  out  1  high while a fetch is outstanding.
- fetch_err  out  1  sticky, set on fetch timeout.

Behaviour:
- Reset (CLB=0, asynchronous, any state):
  - PC=RESET_PC, IR=0, mem_req=0, mem_addr=0, fetch_busy=0, fetch_err=0.
  - State=IDLE, timeout counter=0.
  - A reset mid-fetch abandons the fetch; a late mem_ack after reset is ignored.
- State IDLE:
  - LoadIR=1 → next cycle: mem_req=1, mem_addr=PC sampled at the LoadIR edge, fetch_busy=1, counter=0, state WAIT.
  - mem_ack while IDLE is ignored.
- State WAIT:
  - mem_ack=1 → IR<=mem_rdata, mem_req=0, fetch_busy=0, state IDLE. Opcode/Imm reflect the new IR the following cycle.
  - mem_ack=0 → counter+1.
  - Counter reaches TIMEOUT with no ack → IR<=0 (NOP), fetch_err<=1, mem_req=0, state IDLE.
  - LoadIR during WAIT is ignored; no queueing.
  - mem_addr holds the latched fetch address for the whole WAIT, regardless of PC changes.
  - mem_ack on the same cycle the counter hits TIMEOUT: the ack wins; IR takes mem_rdata and fetch_err is unchanged.
- PC update (any state, every edge):
  - LoadPC=1 → PC <= SelPC ? {zeros, Imm} : RegData.
  - else IncPC=1 → PC <= PC+1, wrapping modulo 2^PC_W (0xFF→0x00).
  - LoadPC has priority over IncPC when both are asserted.
  - Imm used for a jump is the current IR value, not a fetch in flight.
- Latency: LoadIR to mem_req is 1 cycle. With an immediate ack (mem_ack one cycle after mem_req rises), LoadIR to new Opcode is 3 cycles.
- Opcode, Imm and PC are driven directly from registers; no combinational path from inputs to outputs.
- fetch_err is cleared only by reset.

Test Plan:
1. Reset, then memory with 1-cycle ack, word 0x1A at address 0x00, LoadIR pulse → mem_addr=0x00, mem_req high 1 cycle, Opcode=0x1, Imm=0xA, fetch_busy back to 0.
2. IR=0x7C, SelPC=1, LoadPC=1 with IncPC=1 simultaneously → PC=0x0C (LoadPC wins). Then SelPC=0, RegData=0x42, LoadPC → PC=0x42.
3. PC=0xFF, IncPC for 1 cycle → PC=0x00, no fetch_err.
4. Memory acks after 5 cycles; IncPC pulsed twice during WAIT from PC=0x10 → mem_addr holds 0x10 throughout, IR=mem_rdata, PC=0x12. A LoadIR asserted during WAIT triggers no second request.
5. TIMEOUT=15, memory never acks → mem_req drops after 15 WAIT cycles, IR=0x00, Opcode=0, fetch_err=1 and stays set on later successful fetches. Variant with ack on the 15th cycle → IR loaded, fetch_err=0.
6. CLB driven low mid-WAIT, asynchronously between clock edges → mem_req=0, PC=RESET_PC immediately. A mem_ack arriving after CLB returns high leaves IR=0.
